// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// inactive pin levels, reset configuration and the active-high hex glyph table.
package reflet_seg_pkg;

  localparam logic [1:0] ADDR_DIG_LO = 2'd0;
  localparam logic [1:0] ADDR_DIG_HI = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_BRIGHT = 2'd3;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] SEL_OFF    = 4'hF;
  localparam logic       PIN_OFF    = 1'b1;
  localparam logic [3:0] BRIGHT_RST = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

  typedef struct packed {
    logic [3:0][3:0] digit;
    logic [3:0]      dot;
    logic            colon;
    logic [3:0]      bright;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RST = '{digit: '0, dot: '0, colon: 1'b0, bright: BRIGHT_RST};

  // Index n holds the glyph for hex value n, segment order {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU register write port and display pin bundle of the scan controller.
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] segments;
  logic [3:0] seg_select;
  logic       seg_colon;
  logic       seg_dot;
  logic       frame_done;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  segments, seg_select, seg_colon, seg_dot, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output segments, seg_select, seg_colon, seg_dot, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_hex_decode.sv
// Combinational hex-to-seven-segment decoder producing an active-high glyph.
module seg_hex_decode
  import reflet_seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] glyph
);
  assign glyph = GLYPH_TABLE[value];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller: shadow/display registers,
// digit/phase/sub-phase scan counters, IDLE/SCAN control and registered pins.
module seg_scan_ctrl
  import reflet_seg_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);
  localparam int               SUB_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_DIV - 1);

  disp_cfg_t        shadow, shadow_nxt, disp;
  logic             en_sh, en_nxt;
  scan_state_t      state, state_nxt;
  logic [SUB_W-1:0] sub_p0, sub_nxt;
  logic [3:0]       phase_p0, phase_nxt;
  logic [1:0]       digit_p0, digit_nxt;
  logic             wrap_p0, wrap_nxt;
  logic             frame_end, load_disp, lit;
  logic [6:0]       glyph;
  logic [6:0]       seg_p1;
  logic [3:0]       sel_p1;
  logic             dot_p1, colon_p1, fd_p1;

  // Write-through view of the shadow registers: what they hold after this cycle.
  always_comb begin
    shadow_nxt = shadow;
    en_nxt     = en_sh;
    if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_DIG_LO: begin
          shadow_nxt.digit[0] = bus.wr_data[3:0];
          shadow_nxt.digit[1] = bus.wr_data[7:4];
        end
        ADDR_DIG_HI: begin
          shadow_nxt.digit[2] = bus.wr_data[3:0];
          shadow_nxt.digit[3] = bus.wr_data[7:4];
        end
        ADDR_CTRL: begin
          en_nxt           = bus.wr_data[0];
          shadow_nxt.colon = bus.wr_data[1];
          shadow_nxt.dot   = bus.wr_data[5:2];
        end
        default: shadow_nxt.bright = bus.wr_data[3:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= CFG_RST;
      en_sh  <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      en_sh  <= en_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sub_p0   <= '0;
      phase_p0 <= '0;
      digit_p0 <= '0;
      wrap_p0  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sub_p0   <= sub_nxt;
      phase_p0 <= phase_nxt;
      digit_p0 <= digit_nxt;
      wrap_p0  <= wrap_nxt;
    end
  end

  // Counters only advance while staying in SCAN; entering or leaving restarts them at zero.
  always_comb begin
    state_nxt = ST_IDLE;
    if (en_nxt) state_nxt = ST_SCAN;
    sub_nxt   = '0;
    phase_nxt = '0;
    digit_nxt = '0;
    frame_end = (state == ST_SCAN) && (digit_p0 == 2'd3) &&
                (phase_p0 == 4'hF) && (sub_p0 == SUB_LAST);
    if ((state == ST_SCAN) && (state_nxt == ST_SCAN)) begin
      sub_nxt   = sub_p0 + 1'b1;
      phase_nxt = phase_p0;
      digit_nxt = digit_p0;
      if (sub_p0 == SUB_LAST) begin
        sub_nxt   = '0;
        phase_nxt = phase_p0 + 1'b1;
        if (phase_p0 == 4'hF) digit_nxt = digit_p0 + 1'b1;
      end
    end
    load_disp = (state == ST_IDLE) || frame_end;
    wrap_nxt  = frame_end && (state_nxt == ST_SCAN);
  end

  // Display copy tracks the shadow while idle so the first frame after enable is current.
  always_ff @(posedge clk) begin
    if (reset) disp <= CFG_RST;
    else if (load_disp) disp <= shadow_nxt;
  end

  seg_hex_decode u_dec (
    .value (disp.digit[digit_p0]),
    .glyph (glyph)
  );

  assign lit = (state == ST_SCAN) && (phase_p0 != 4'd0) && (phase_p0 <= disp.bright);

  // ---- output stage p1: pins reflect the previous cycle's counter state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p1   <= SEG_OFF;
      sel_p1   <= SEL_OFF;
      dot_p1   <= PIN_OFF;
      colon_p1 <= PIN_OFF;
      fd_p1    <= 1'b0;
    end else begin
      fd_p1 <= wrap_p0 && (state == ST_SCAN);
      if (lit) begin
        seg_p1   <= ~glyph;
        sel_p1   <= ~(4'b0001 << digit_p0);
        dot_p1   <= ~disp.dot[digit_p0];
        colon_p1 <= ~disp.colon;
      end else begin
        seg_p1   <= SEG_OFF;
        sel_p1   <= SEL_OFF;
        dot_p1   <= PIN_OFF;
        colon_p1 <= PIN_OFF;
      end
    end
  end

  assign bus.segments   = seg_p1;
  assign bus.seg_select = sel_p1;
  assign bus.seg_dot    = dot_p1;
  assign bus.seg_colon  = colon_p1;
  assign bus.frame_done = fd_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position reference model checked
// every cycle, a hex glyph vector table, and directed multi-cycle sequences.
module tb_seg_scan_ctrl;
  import reflet_seg_pkg::*;

  localparam int D     = 2;
  localparam int FRAME = 64 * D;

  typedef struct {
    logic [3:0] val;
    logic [6:0] exp_seg;
  } hex_vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  hex_vec_t vecs [16];

  // Reference model: scan position counted in cycles since enable, snapshot per frame.
  bit         m_valid = 1'b0;
  bit         m_scan  = 1'b0;
  int         m_pos   = 0;
  logic [3:0] sh_dig [4];
  logic [3:0] sn_dig [4];
  logic [3:0] sh_dot, sn_dot, sh_bright, sn_bright;
  logic       sh_colon, sn_colon, sh_en;

  int s_lit [4];
  int s_dot2, s_dotbad, s_colon, s_gbad, s_fd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_snap();
    for (int i = 0; i < 4; i++) sn_dig[i] = sh_dig[i];
    sn_dot = sh_dot; sn_colon = sh_colon; sn_bright = sh_bright;
  endtask

  task automatic tick();
    logic       w, r;
    logic [1:0] a;
    logic [7:0] d;
    logic [6:0] e_seg;
    logic [3:0] e_sel;
    logic       e_dot, e_colon, e_fd;
    int         ph, dg;
    w = bus.wr_en; a = bus.wr_addr; d = bus.wr_data; r = reset;
    @(posedge clk);
    e_seg = 7'h7F; e_sel = 4'hF; e_dot = 1'b1; e_colon = 1'b1; e_fd = 1'b0;
    if (!r && m_scan) begin
      ph = (m_pos / D) % 16;
      dg = (m_pos / (16 * D)) % 4;
      e_fd = (m_pos != 0) && (m_pos % FRAME == 0);
      if (ph >= 1 && ph <= int'(sn_bright)) begin
        e_seg   = vecs[sn_dig[dg]].exp_seg;
        e_sel   = 4'hF ^ (4'b0001 << dg);
        e_dot   = ~sn_dot[dg];
        e_colon = ~sn_colon;
      end
    end
    if (r) begin
      for (int i = 0; i < 4; i++) begin sh_dig[i] = 4'h0; sn_dig[i] = 4'h0; end
      sh_dot = 4'h0; sh_colon = 1'b0; sh_bright = 4'hF; sh_en = 1'b0;
      model_snap();
      m_scan = 1'b0; m_pos = 0; m_valid = 1'b1;
    end else begin
      if (w) begin
        case (a)
          2'd0: begin sh_dig[0] = d[3:0]; sh_dig[1] = d[7:4]; end
          2'd1: begin sh_dig[2] = d[3:0]; sh_dig[3] = d[7:4]; end
          2'd2: begin sh_en = d[0]; sh_colon = d[1]; sh_dot = d[5:2]; end
          default: sh_bright = d[3:0];
        endcase
      end
      if (sh_en) begin
        if (!m_scan) begin
          m_scan = 1'b1; m_pos = 0; model_snap();
        end else begin
          m_pos++;
          if (m_pos % FRAME == 0) model_snap();
        end
      end else begin
        m_scan = 1'b0;
      end
    end
    #1;
    if (bus.frame_done === 1'b1) fd_count++;
    if (m_valid)
      check("model", {bus.segments, bus.seg_select, bus.seg_dot, bus.seg_colon, bus.frame_done},
            {e_seg, e_sel, e_dot, e_colon, e_fd});
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      tick();
      if (bus.frame_done === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s: frame_done absent, got 0 expected 1 within %0d cycles", name, 3 * FRAME);
    end
  endtask

  task automatic sample(input logic [3:0][6:0] eg);
    logic [3:0] m;
    if (bus.frame_done === 1'b1) s_fd++;
    for (int i = 0; i < 4; i++) begin
      m = 4'b0001 << i;
      if (bus.seg_select === ~m) begin
        s_lit[i]++;
        if (bus.segments !== eg[i]) s_gbad++;
        if (i == 2 && bus.seg_dot === 1'b0) s_dot2++;
      end
    end
    if (bus.seg_dot === 1'b0 && bus.seg_select !== 4'b1011) s_dotbad++;
    if (bus.seg_colon === 1'b0) s_colon++;
  endtask

  // Collects one full frame of pin activity starting at the current frame_done sample.
  task automatic measure(input logic [3:0][6:0] eg);
    for (int i = 0; i < 4; i++) s_lit[i] = 0;
    s_dot2 = 0; s_dotbad = 0; s_colon = 0; s_gbad = 0; s_fd = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick();
      sample(eg);
    end
  endtask

  task automatic check_lit(input string name, input int exp);
    for (int i = 0; i < 4; i++) check($sformatf("%s_lit%0d", name, i), s_lit[i], exp);
    check({name, "_glyph"}, s_gbad, 0);
    check({name, "_fd_in_frame"}, s_fd, 1);
  endtask

  localparam logic [3:0][6:0] EG_MAIN = {7'h08, 7'h00, 7'h79, 7'h40};
  localparam logic [3:0][6:0] EG_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};

  initial begin
    int early;
    bit found;
    logic [7:0] rd;
    logic [1:0] ra;

    vecs = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
             '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
             '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
             '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}};

    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'h00;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;

    // Idle after reset
    fd_count = 0;
    idle(200);
    check("idle_seg", bus.segments, 7'h7F);
    check("idle_sel", bus.seg_select, 4'hF);
    check("idle_dot_colon", {bus.seg_dot, bus.seg_colon}, 2'b11);
    check("idle_fd_count", fd_count, 0);

    // Glyph table plus enable latency on every entry
    for (int i = 0; i < 16; i++) begin
      write(ADDR_CTRL, 8'h00);
      write(ADDR_DIG_LO, {4'h0, vecs[i].val});
      write(ADDR_CTRL, 8'h01);
      idle(D);
      check($sformatf("hex%h_dark_sel", vecs[i].val), bus.seg_select, 4'hF);
      tick();
      check($sformatf("hex%h_sel", vecs[i].val), bus.seg_select, 4'hE);
      check($sformatf("hex%h_seg", vecs[i].val), bus.segments, vecs[i].exp_seg);
    end

    // Full brightness frame
    write(ADDR_DIG_LO, 8'h10);
    write(ADDR_DIG_HI, 8'hA8);
    write(ADDR_BRIGHT, 8'h0F);
    wait_fd("main_wait");
    wait_fd("main_wait2");
    measure(EG_MAIN);
    check_lit("b15", 30 * D / 2);
    tick();
    check("b15_fd_period", bus.frame_done, 1'b1);

    write(ADDR_BRIGHT, 8'h03);
    wait_fd("b3_wait");
    measure(EG_MAIN);
    check_lit("b3", 3 * D);
    tick();
    check("b3_fd_period", bus.frame_done, 1'b1);

    write(ADDR_BRIGHT, 8'h00);
    wait_fd("b0_wait");
    measure(EG_MAIN);
    check_lit("b0", 0);
    tick();
    check("b0_fd_period", bus.frame_done, 1'b1);

    // Dot on digit 2 and colon
    write(ADDR_BRIGHT, 8'h0F);
    write(ADDR_CTRL, 8'h13);
    wait_fd("dot_wait");
    measure(EG_MAIN);
    check_lit("dot", 15 * D);
    check("dot_digit2", s_dot2, 15 * D);
    check("dot_elsewhere", s_dotbad, 0);
    check("colon_lit", s_colon, 60 * D);
    tick();
    check("dot_fd_period", bus.frame_done, 1'b1);

    // Mid-frame write of digit 0 while digit 1 is shown
    idle(40);
    check("mid_on_digit1", bus.seg_select, 4'hD);
    write(ADDR_DIG_LO, 8'h1F);
    early = 0; found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      tick();
      if (bus.frame_done === 1'b1) found = 1'b1;
      else if (bus.seg_select === 4'hE && bus.segments === 7'h0E) early++;
    end
    check("mid_fd_found", found, 1'b1);
    check("mid_no_tearing", early, 0);
    idle(3);
    check("mid_new_sel", bus.seg_select, 4'hE);
    check("mid_new_seg", bus.segments, 7'h0E);

    // Write landing exactly on the frame-end cycle
    idle(FRAME - 5);
    write(ADDR_DIG_LO, 8'h15);
    tick();
    check("bnd_fd", bus.frame_done, 1'b1);
    idle(2);
    check("bnd_sel", bus.seg_select, 4'hE);
    check("bnd_seg", bus.segments, 7'h12);

    // Disable mid-slot
    write(ADDR_CTRL, 8'h00);
    check("dis_t1_sel", bus.seg_select, 4'hE);
    tick();
    check("dis_t2_sel", bus.seg_select, 4'hF);
    check("dis_t2_seg", bus.segments, 7'h7F);
    fd_count = 0;
    idle(FRAME);
    check("dis_no_fd", fd_count, 0);

    // Reset mid-slot, then re-enable with cleared registers
    write(ADDR_CTRL, 8'h01);
    idle(5);
    check("rst_pre_sel", bus.seg_select, 4'hE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_sel", bus.seg_select, 4'hF);
    check("rst_seg", bus.segments, 7'h7F);
    check("rst_fd", bus.frame_done, 1'b0);
    write(ADDR_CTRL, 8'h01);
    idle(D + 1);
    check("rst_reen_sel", bus.seg_select, 4'hE);
    check("rst_reen_seg", bus.segments, 7'h40);
    wait_fd("rst_wait");
    measure(EG_ZERO);
    check_lit("rst_b15", 15 * D);

    // Randomized register traffic against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        ra = 2'($urandom_range(0, 3));
        rd = 8'($urandom);
        if (ra == ADDR_CTRL) rd[0] = ($urandom_range(0, 15) != 0);
        write(ra, rd);
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexed four-digit seven-segment display controller for the `clock_cpu` peripheral set. It holds the digit, decimal-point, colon and brightness settings written by the CPU over a simple register port. It scans the digits in time-multiplexed fashion with per-digit anti-ghosting blanking and 16-level brightness. It drives the `segments`, `seg_select`, `seg_colon` and `seg_dot` pins and updates the displayed frame atomically, so no tearing is visible.

## Interface
- `CLK_DIV`, default 1000: clock cycles per sub-phase; legal range ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. The block has one clock; reset is synchronous and active-high.
- `wr_en`  in  1  register write strobe; one write per asserted cycle.
- `wr_addr`  in  2  register address.
- `wr_data`  in  8  write data.
- `segments`  out  7  {g,f,e,d,c,b,a}, active-low.
- `seg_select`  out  4  digit select, active-low; bit i selects digit i (digit 0 is rightmost).
- `seg_colon`  out  1  colon, active-low.
- `seg_dot`  out  1  decimal point of the current digit, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary while enabled.

## Operation
- Register map (shadow registers, written immediately):
  - Addr 0: [3:0] digit0, [7:4] digit1.
  - Addr 1: [3:0] digit2, [7:4] digit3.
  - Addr 2: bit0 `enable`, bit1 `colon`, [5:2] dot mask (bit 2+i controls digit i), [7:6] ignored.
  - Addr 3: [3:0] `bright`, [7:4] ignored.
- Reset values:
  - Digits = 0, control = 0, bright = 15.
  - All outputs inactive: `segments`=7'h7F, `seg_select`=4'hF, `seg_colon`=1, `seg_dot`=1, `frame_done`=0.
- Display registers are copied from the shadow registers at each frame boundary and on the first cycle after `enable` rises.
- A write in the same cycle as a boundary is included in the copy (write-through).
- States:
  - IDLE: outputs inactive, counters held at 0.
  - SCAN: entered when `enable`=1.
  - Clearing `enable` returns the block to IDLE next cycle from any point, mid-slot included.
- Scan hierarchy:
  - Sub-phase counter counts 0..CLK_DIV-1.
  - Phase counter counts 0..15.
  - Digit counter counts 0..3.
  - One slot = 16·CLK_DIV cycles; one frame = 64·CLK_DIV cycles.
  - After digit 3, phase 15 the counters wrap to digit 0, and `frame_done` pulses.
- Lit condition: phase ≥1 and phase ≤ `bright`.
  - Phase 0 is always dark (anti-ghosting guard).
  - `bright`=0 keeps the display dark, but scanning and `frame_done` continue.
- While lit:
  - `seg_select` = ~(1<<digit).
  - `segments` = hex decode of the digit value.
  - `seg_dot` = ~dotmask[digit].
  - `seg_colon` = ~colon.
- While dark, all outputs are inactive.
- Hex decode, shown active-low: 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E. All 16 codes follow the standard hex glyph set.

## Timing
- All outputs are registered: each output reflects the counter state of the previous cycle.
- Enable latency:
  - Write `enable`=1 at cycle t; counters start at digit 0, phase 0 on t+1.
  - First lit output (digit 0, with `bright`≥1) appears at t+1+CLK_DIV+1.
- `frame_done` is high for exactly one cycle per frame. It is asserted together with the first output cycle of digit 0 phase 0 of the new frame.
- Disable: outputs are inactive 2 cycles after the write cycle. No `frame_done` is generated on disable.
- Reset mid-frame: outputs are inactive from the cycle after `reset` is sampled. Shadow registers and display registers are reset.
- Back-to-back writes are all accepted. The last value before the boundary wins.

## Structure
- Package `reflet_seg_pkg` holds:
  - Register address constants.
  - Inactive-level constants.
  - Hex glyph table, stored active-high; inversion happens at the output register.
- Sub-module `seg_hex_decode`: combinational, 4-bit in → 7-bit active-high glyph.
- The top level holds the shadow/display registers, counters, IDLE/SCAN state and output registers.

## Test plan
All scenarios use CLK_DIV=2.
- Reset, then 200 idle cycles → `segments`=7'h7F, `seg_select`=4'hF, `frame_done` never pulses.
- Write addr0=8'h10, addr1=8'hA8, addr2=8'h01, `bright`=15 → per frame, digits 0..3 show 7'h40, 7'h79, 7'h00, 7'h08 respectively, each lit 30 cycles after 2 dark cycles; `frame_done` period is 128 cycles.
- Set `bright`=3 → each slot is lit exactly 6 cycles (phases 1..3). Set `bright`=0 → fully dark, while `frame_done` continues every 128 cycles.
- Set dot mask 4'b0100 and `colon`=1 → `seg_dot`=0 only during digit 2 lit cycles; `seg_colon`=0 during every lit cycle.
- Write digit0=F mid-frame while digit 1 is displayed → digit 0 still shows the old glyph for the rest of the frame, then 7'h0E after `frame_done`. A write on the boundary cycle itself shows the new value immediately.
- Clear `enable` mid-slot, and separately assert `reset` mid-slot → outputs inactive within 2 cycles and 1 cycle respectively. After reset, digits read 0 on re-enable and `bright`=15.
